// File: rtl/instr_link_pkg.sv
// ----------------------------------------------------------------------------
// instr_link_pkg
// Shared definitions for the host-to-pump instruction link:
//   INSTR_W   - instruction word width carried by the link
//   SYM_*     - 2-bit link symbols, one per UART byte
//   state_e   - serializer FSM states
// ----------------------------------------------------------------------------
package instr_link_pkg;

    localparam int INSTR_W = 13;

    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_ONE  = 2'b01;
    localparam logic [1:0] SYM_LOAD = 2'b10;
    localparam logic [1:0] SYM_RUN  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REARM = 3'd1,
        ST_POP   = 3'd2,
        ST_BIT   = 3'd3,
        ST_RUN   = 3'd4,
        ST_WAIT  = 3'd5
    } state_e;

endpackage

// File: rtl/instr_fifo.sv
// ----------------------------------------------------------------------------
// instr_fifo
// Synchronous single-clock FIFO holding queued instruction words.
// Ports:
//   clk, rst       - clock, synchronous active-high reset (empties the queue)
//   wr_en, wr_data - push; ignored while full (even with a pop that cycle)
//   rd_en          - pop the head word; ignored while empty
//   head           - word at the head of the queue
//   empty, full    - decoded from the registered occupancy counter
// ----------------------------------------------------------------------------
module instr_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              wr_ok;
    logic              rd_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;
    assign head  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/instr_serializer.sv
// ----------------------------------------------------------------------------
// instr_serializer
// Queues 13-bit instructions and serializes each one MSB-first into 2-bit
// link symbols (one per UART byte), followed by a run marker once the queue
// drains.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   wr_en, wr_data    - queue an instruction (dropped while full)
//   full              - queue holds DEPTH words
//   go                - start a batch (ignored while busy)
//   busy              - batch in progress
//   tx_start, tx_sym  - symbol handshake to the UART transmitter
//   tx_done_tick      - transmitter finished the current byte
//   sent_count        - complete words sent since reset (wraps)
// Build option:
//   INSTR_SERIALIZER_REARM_EN - each batch is preceded by a re-arm/load
//                               symbol (10) that returns the receiver to
//                               load state.
// ----------------------------------------------------------------------------
module instr_serializer
    import instr_link_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IW    = INSTR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_data,
    output logic          full,
    input  logic          go,
    output logic          busy,
    output logic          tx_start,
    output logic [1:0]    tx_sym,
    input  logic          tx_done_tick,
    output logic [7:0]    sent_count
);

    localparam int IDXW = $clog2(IW);

    state_e          state_q, state_d;
    logic [1:0]      sym_q,   sym_d;
    logic [7:0]      cnt_q,   cnt_d;
    logic [IW-1:0]   shreg_q, shreg_d;
    logic [IDXW-1:0] idx_q,   idx_d;

    logic            pop;
    logic            fifo_empty;
    logic [IW-1:0]   fifo_head;

    instr_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (IW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .head    (fifo_head),
        .empty   (fifo_empty),
        .full    (full)
    );

    always_comb begin
        state_d = state_q;
        sym_d   = sym_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        pop     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
`ifdef INSTR_SERIALIZER_REARM_EN
                    state_d = ST_REARM;
`else
                    state_d = fifo_empty ? ST_RUN : ST_POP;
`endif
                end
            end
            ST_REARM: begin
                sym_d   = SYM_LOAD;
                state_d = ST_WAIT;
            end
            ST_POP: begin
                shreg_d = fifo_head;
                idx_d   = IDXW'(IW - 1);
                pop     = 1'b1;
                state_d = ST_BIT;
            end
            ST_BIT: begin
                sym_d   = {1'b0, shreg_q[idx_q]};
                state_d = ST_WAIT;
            end
            ST_RUN: begin
                sym_d   = SYM_RUN;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // The symbol still held on tx_sym tells us which byte just
                // completed, so no separate "return state" register is needed.
                if (tx_done_tick) begin
                    if (sym_q == SYM_RUN) begin
                        state_d = ST_IDLE;
`ifdef INSTR_SERIALIZER_REARM_EN
                    end else if (sym_q == SYM_LOAD) begin
                        state_d = fifo_empty ? ST_RUN : ST_POP;
`endif
                    end else if (idx_q != '0) begin
                        idx_d   = idx_q - 1'b1;
                        state_d = ST_BIT;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = fifo_empty ? ST_RUN : ST_POP;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state: reset applies here only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sym_q   <= SYM_ZERO;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            sym_q   <= sym_d;
            cnt_q   <= cnt_d;
        end
    end

    // Word datapath: always loaded in POP before use, so left unreset.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        idx_q   <= idx_d;
    end

    assign busy       = (state_q != ST_IDLE);
    assign tx_start   = (state_q == ST_BIT) || (state_q == ST_RUN) ||
                        (state_q == ST_REARM);
    // While issuing, present the new symbol; otherwise hold the last one.
    assign tx_sym     = tx_start ? sym_d : sym_q;
    assign sent_count = cnt_q;

endmodule

// File: tb/tb_instr_serializer.sv
module tb_instr_serializer;

    localparam int DEPTH = 16;
    localparam int IW    = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_data = '0;
    logic          full;
    logic          go = 1'b0;
    logic          busy;
    logic          tx_start;
    logic [1:0]    tx_sym;
    logic          tx_done_tick = 1'b0;
    logic [7:0]    sent_count;

    instr_serializer #(.DEPTH(DEPTH), .IW(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .go           (go),
        .busy         (busy),
        .tx_start     (tx_start),
        .tx_sym       (tx_sym),
        .tx_done_tick (tx_done_tick),
        .sent_count   (sent_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model
    logic [IW-1:0] model_q[$];   // words queued, not yet committed to a batch
    logic [1:0]    exp_q[$];     // symbols expected on the link, in order
    bit            model_busy = 0;
    int            model_sent = 0;
    int            lat = 3;      // transmitter byte time in cycles
    int            nstarts = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Append a word's symbols, MSB first.
    task automatic push_word(input logic [IW-1:0] w);
        for (int b = IW - 1; b >= 0; b--) exp_q.push_back({1'b0, w[b]});
        model_sent = (model_sent + 1) % 256;
    endtask

    task automatic wr(input logic [IW-1:0] w);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_data = w;
        if (model_busy) begin
            // Mid-batch write: lands before the trailing run marker.
            logic [1:0] last;
            last = exp_q.pop_back();
            push_word(w);
            exp_q.push_back(last);
        end else if (model_q.size() < DEPTH) begin
            model_q.push_back(w);
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_go(output logic s1, output logic s2);
        @(posedge clk); #1;
        go = 1'b1;
        if (!model_busy) begin
`ifdef INSTR_SERIALIZER_REARM_EN
            exp_q.push_back(2'b10);
`endif
            while (model_q.size() > 0) push_word(model_q.pop_front());
            exp_q.push_back(2'b11);
            model_busy = 1;
        end
        @(posedge clk); #1;
        go = 1'b0;
        @(negedge clk); s1 = tx_start;
        @(negedge clk); s2 = tx_start;
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        @(negedge clk);
        while (busy && i < 5000) begin @(negedge clk); i++; end
        check({name, "_timeout"}, int'(busy), 0);
        model_busy = 0;
        check({name, "_leftover"}, exp_q.size(), 0);
        exp_q.delete();
        check({name, "_sent_count"}, int'(sent_count), model_sent);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_starts(input int n, input string name);
        int target, i;
        target = nstarts + n;
        i = 0;
        while (nstarts < target && i < 2000) begin @(negedge clk); i++; end
        check({name, "_starts_timeout"}, int'(nstarts >= target), 1);
    endtask

    // Transmitter model: answer every tx_start with tx_done_tick lat cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start && !rst) begin
                repeat (lat) @(posedge clk);
                #1 tx_done_tick = 1'b1;
                @(posedge clk);
                #1 tx_done_tick = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    logic [1:0] last_sym = 2'b00;
    bit         prev_start = 0;
    bit         busy_fall_pend = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                last_sym = 2'b00;
                prev_start = 0;
                busy_fall_pend = 0;
            end else begin
                if (busy_fall_pend) begin
                    check("busy_fall", int'(busy), 0);
                    busy_fall_pend = 0;
                end
                if (tx_start) begin
                    nstarts++;
                    check("start_spacing", int'(prev_start), 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_sym", int'(tx_sym), -1);
                    end else begin
                        logic [1:0] e;
                        e = exp_q.pop_front();
                        check("tx_sym", int'(tx_sym), int'(e));
                    end
                    last_sym = tx_sym;
                end else if (busy) begin
                    check("sym_hold", int'(tx_sym), int'(last_sym));
                    if (tx_done_tick && last_sym == 2'b11) busy_fall_pend = 1;
                end
                prev_start = tx_start;
            end
        end
    end

    initial begin
        logic s1, s2;
        logic [IW-1:0] w;
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_full", int'(full), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_tx_start", int'(tx_start), 0);
        check("rst_tx_sym", int'(tx_sym), 0);
        check("rst_sent_count", int'(sent_count), 0);

        // Single word
        lat = 3;
        wr(13'h1ABC);
        pulse_go(s1, s2);
`ifdef INSTR_SERIALIZER_REARM_EN
        check("first_start_rearm", int'(s1), 1);
`else
        check("first_start_n1", int'(s1), 0);
        check("first_start_n2", int'(s2), 1);
`endif
        wait_idle("single");

        // Fill beyond capacity
        for (int i = 0; i < DEPTH + 1; i++) begin
            wr(IW'($urandom));
            @(negedge clk);
            check("full_flag", int'(full), int'(model_q.size() == DEPTH));
        end
        pulse_go(s1, s2);
        wait_idle("overflow");

        // Empty queue, second go while busy
        pulse_go(s1, s2);
        pulse_go(s1, s2);
        wait_idle("empty_go");
        check("empty_sent_count", int'(sent_count), model_sent);

        // Write during a batch
        wr(13'h0F0F);
        pulse_go(s1, s2);
        wait_starts(5, "midwr");
        wr(13'h1234);
        wait_idle("midwr");

        // Reset mid-word
        wr(13'h1555);
        wr(13'h0AAA);
        pulse_go(s1, s2);
        wait_starts(7, "rstmid");
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        model_q.delete();
        model_busy = 0;
        model_sent = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_tx_start", int'(tx_start), 0);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_full", int'(full), 0);
        check("rstmid_sent_count", int'(sent_count), 0);
        repeat (10) @(negedge clk);
        pulse_go(s1, s2);
        wait_idle("after_rst");

        // Word with a single set LSB
        wr(13'h0001);
        pulse_go(s1, s2);
        wait_idle("lsb_only");

        // Randomized batches
        for (int b = 0; b < 6; b++) begin
            lat = $urandom_range(1, 4);
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                w = IW'($urandom);
                wr(w);
            end
            pulse_go(s1, s2);
            wait_idle("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
